uart_tx_scheduler: RTL

- Sits between the UART RX/comparator side and a byte-level UART transmitter.
- Arbitrates two requesters: a "reply" request (comparator match → send fixed "POLO\r\n") and an "echo" request (one received byte).
- Sequences each message byte by byte over a start/busy handshake, then enforces an inter-message gap.
- Only block that drives the transmitter's start and data inputs.

---
 rtl/uart_sched_pkg.sv | 33 +++
 rtl/uart_tx_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  // Sequencer states: pick a message, issue a byte, wait for the
  // transmitter to take it, wait for it to finish, then hold a gap.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4
  } sched_state_t;

  // Which requester owns the message currently being sequenced.
  typedef enum logic {
    SRC_REPLY = 1'b0,
    SRC_ECHO  = 1'b1
  } sched_src_t;

  localparam int DEF_REPLY_LEN    = 6;
  localparam int DEF_GAP_CYCLES   = 16;
  localparam int DEF_BUSY_TIMEOUT = 8;

  // One counter serves both the gap and the busy-rise timeout.
  localparam int CNT_W = 16;

  // Reply message "POLO\r\n"; the unused tail entries are never indexed
  // because the byte index stops at REPLY_LEN-1.
  localparam logic [7:0] REPLY_ROM [0:7] = '{
    8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h0D, 8'h0A, 8'h00, 8'h00
  };

endpackage

// File: rtl/uart_tx_scheduler.sv
// Arbitrates reply and echo requests and sequences their bytes into a
// byte-level UART transmitter over a tx_start / tx_busy handshake.
//
// Handshake: the scheduler raises tx_start for exactly one cycle with
// tx_data valid only while tx_busy is low; the transmitter acknowledges by
// raising tx_busy and holds it for the whole frame. A byte is complete when
// tx_busy falls again. If tx_busy never rises within BUSY_TIMEOUT cycles the
// message is abandoned and tx_fault latches.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int REPLY_LEN    = DEF_REPLY_LEN,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_reply,
  input  logic       req_echo,
  input  logic [7:0] echo_byte,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       active,
  output logic       grant_reply,
  output logic       grant_echo,
  output logic       echo_drop,
  output logic       tx_fault,
  output logic [2:0] dbg_state
);

  // Last-value constants; a zero parameter collapses to a single cycle.
  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] TO_LAST =
    (BUSY_TIMEOUT > 0) ? CNT_W'(BUSY_TIMEOUT - 1) : '0;
  localparam logic [2:0] IDX_LAST =
    (REPLY_LEN > 0) ? 3'(REPLY_LEN - 1) : 3'd0;

  sched_state_t     state_q, state_d;
  sched_src_t       src_q, src_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             grant_reply_q, grant_reply_d;
  logic             grant_echo_q, grant_echo_d;
  logic             tx_fault_q, tx_fault_d;
  logic [7:0]       echo_cur_q, echo_cur_d;

  logic             reply_pend_q, reply_pend_d;
  logic             echo_pend_q, echo_pend_d;
  logic [7:0]       echo_buf_q, echo_buf_d;
  logic             echo_drop_q, echo_drop_d;
  logic             echo_hold;

  logic             take_reply;
  logic             take_echo;

  // Sequencer state register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      src_q         <= SRC_REPLY;
      idx_q         <= 3'd0;
      cnt_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      grant_reply_q <= 1'b0;
      grant_echo_q  <= 1'b0;
      tx_fault_q    <= 1'b0;
      echo_cur_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      grant_reply_q <= grant_reply_d;
      grant_echo_q  <= grant_echo_d;
      tx_fault_q    <= tx_fault_d;
      echo_cur_q    <= echo_cur_d;
    end
  end

  // Next-state and output decode; grants and tx_start are one-cycle pulses.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    grant_reply_d = 1'b0;
    grant_echo_d  = 1'b0;
    tx_fault_d    = tx_fault_q;
    echo_cur_d    = echo_cur_q;
    take_reply    = 1'b0;
    take_echo     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (reply_pend_q) begin
          take_reply    = 1'b1;
          grant_reply_d = 1'b1;
          idx_d         = 3'd0;
          src_d         = SRC_REPLY;
          state_d       = S_ISSUE;
        end else if (echo_pend_q) begin
          // Snapshot the byte so a new echo request accepted in this same
          // cycle cannot change the byte of the message being started.
          take_echo    = 1'b1;
          grant_echo_d = 1'b1;
          src_d        = SRC_ECHO;
          echo_cur_d   = echo_buf_q;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = (src_q == SRC_REPLY) ? REPLY_ROM[idx_q] : echo_cur_q;
          cnt_d      = '0;
          state_d    = S_WAIT_HI;
        end
      end

      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == TO_LAST) begin
          tx_fault_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (src_q == SRC_REPLY && idx_q < IDX_LAST) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_ISSUE;
          end else begin
            cnt_d   = '0;
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Pending-request bookkeeping: a grant clears its flag, a request in the
  // same cycle re-sets it; a second echo while one is still waiting is lost.
  always_comb begin
    echo_hold    = echo_pend_q && !take_echo;
    reply_pend_d = (reply_pend_q && !take_reply) || req_reply;
    echo_pend_d  = echo_hold || req_echo;
    echo_buf_d   = (req_echo && !echo_hold) ? echo_byte : echo_buf_q;
    echo_drop_d  = echo_drop_q || (req_echo && echo_hold);
  end

  // Pending flags, echo buffer and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reply_pend_q <= 1'b0;
      echo_pend_q  <= 1'b0;
      echo_buf_q   <= 8'h00;
      echo_drop_q  <= 1'b0;
    end else begin
      reply_pend_q <= reply_pend_d;
      echo_pend_q  <= echo_pend_d;
      echo_buf_q   <= echo_buf_d;
      echo_drop_q  <= echo_drop_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign active      = (state_q != S_IDLE);
  assign grant_reply = grant_reply_q;
  assign grant_echo  = grant_echo_q;
  assign echo_drop   = echo_drop_q;
  assign tx_fault    = tx_fault_q;
  assign dbg_state   = state_q;

endmodule
